// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix_feeder / matrix_mult pair.
// State encodings, default geometry and the job-size helper live here.
package matrix_pkg;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_START     = 3'd1,
    ST_GAP       = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } feeder_state_e;

  localparam int DW_DEF = 8;
  localparam int M_DEF  = 8;
  localparam int N_DEF  = 8;

  // One job holds matrix A followed by matrix B, both M x N.
  function automatic int total_elems(input int m, input int n);
    return 2 * m * n;
  endfunction

endpackage

// File: rtl/feeder_ram.sv
// Job buffer for matrix_feeder: register array with synchronous write and
// combinational read through one shared address port.
module feeder_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // No reset: contents are don't-care until a job has been loaded.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/matrix_feeder.sv
// Buffers one A+B operand job from a valid/ready source and replays it into
// matrix_mult as start pulse, GAP idle cycles, then one element per clock.
//
// state        | meaning
// ST_LOAD      | accepting elements, in_ready high
// ST_START     | mm_start high for this single cycle
// ST_GAP       | GAP idle cycles before the first element
// ST_STREAM    | one buffered element on mm_data per cycle
// ST_WAIT_DONE | job replayed, waiting for mm_done
module matrix_feeder
  import matrix_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int M   = M_DEF,
  parameter int N   = N_DEF,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mm_start,
  output logic [DW-1:0] mm_data,
  input  logic          mm_done,
  output logic          busy
);

  localparam int TOTAL = total_elems(M, N);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? GAP - 1 : 0);

  feeder_state_e state, next_state;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [GW-1:0] gap_cnt;
  logic          hs, wr_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  assign in_ready = (state == ST_LOAD);
  assign hs       = in_valid & in_ready;
  assign wr_last  = (wr_cnt == LAST);
  assign ram_addr = (state == ST_LOAD) ? wr_cnt[AW-1:0] : rd_cnt[AW-1:0];

  feeder_ram #(
    .DW   (DW),
    .DEPTH(TOTAL),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (hs),
    .addr (ram_addr),
    .wdata(in_data),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= next_state;
  end

  // rd_cnt runs one ahead of mm_data, so rd_cnt wrapping to 0 marks the
  // cycle in which the last element is on the bus.
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:      if (hs && wr_last) next_state = ST_START;
      ST_START:     next_state = (GAP > 0) ? ST_GAP : ST_STREAM;
      ST_GAP:       if (gap_cnt == '0) next_state = ST_STREAM;
      ST_STREAM:    if (rd_cnt == '0) next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (mm_done) next_state = ST_LOAD;
      default:      next_state = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      gap_cnt  <= '0;
      mm_start <= 1'b0;
      mm_data  <= '0;
      busy     <= 1'b0;
    end else begin
      mm_start <= (next_state == ST_START);
      busy     <= (next_state != ST_LOAD);

      if (hs) wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
      else if (state == ST_START) wr_cnt <= '0;

      if (state == ST_START) gap_cnt <= GAP_INIT;
      else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

      // Registered from next_state so element 0 lands exactly 1+GAP after start.
      if (next_state == ST_STREAM) begin
        mm_data <= ram_rdata;
        rd_cnt  <= (rd_cnt == LAST) ? '0 : rd_cnt + CW'(1);
      end else begin
        mm_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder with M=N=2, DW=8: one instance with GAP=1
// and one with GAP=0 (the latter held in reset until its own scenario).
`timescale 1ns/1ps
module tb_matrix_feeder;

  logic       clk = 1'b0;
  logic       reset, reset0;
  logic       in_valid, mm_done;
  logic [7:0] in_data;
  logic       in_ready1, mm_start1, busy1;
  logic [7:0] mm_data1;
  logic       in_ready0, mm_start0, busy0;
  logic [7:0] mm_data0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] job_a [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [7:0] job_b [8] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};

  always #100 clk = ~clk;

  matrix_feeder #(.DW(8), .M(2), .N(2), .GAP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mm_start(mm_start1), .mm_data(mm_data1),
    .mm_done(mm_done), .busy(busy1)
  );

  matrix_feeder #(.DW(8), .M(2), .N(2), .GAP(0)) dut0 (
    .clk(clk), .reset(reset0), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mm_start(mm_start0), .mm_data(mm_data0),
    .mm_done(mm_done), .busy(busy0)
  );

  function automatic logic rdy_of(input bit s);
    return s ? in_ready0 : in_ready1;
  endfunction
  function automatic logic start_of(input bit s);
    return s ? mm_start0 : mm_start1;
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? busy0 : busy1;
  endfunction
  function automatic logic [7:0] data_of(input bit s);
    return s ? mm_data0 : mm_data1;
  endfunction

  // Pushes one job; bubbles=1 drops in_valid on every odd cycle.
  task automatic drive_job(input logic [7:0] d[8], input bit bubbles, input bit sel,
                           output int cycles);
    int idx = 0;
    cycles = 0;
    while (idx < 8 && cycles < 100) begin
      @(negedge clk);
      in_valid = bubbles ? (cycles % 2 == 0) : 1'b1;
      in_data  = d[idx];
      if (in_valid && rdy_of(sel)) idx++;
      cycles++;
    end
    if (idx < 8) begin
      n_cmp++; n_bad++;
      $display("FAIL drive_timeout: accepted %0d of 8 elements", idx);
    end
  endtask

  // Waits for mm_start, then records mm_data for the 12 cycles after it.
  task automatic watch(input bit sel, input int done_at, output bit found,
                       output int wait_cycles, output logic [7:0] seq[12],
                       output int starts, output int busy_lows);
    found = 0; wait_cycles = 0; starts = 0; busy_lows = 0;
    for (int j = 0; j < 12; j++) seq[j] = 8'h00;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      mm_done  = 1'b0;
      if (start_of(sel)) found = 1; else wait_cycles++;
    end
    if (found) begin
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        mm_done = (j == done_at);
        seq[j]  = data_of(sel);
        starts    += start_of(sel) ? 1 : 0;
        busy_lows += busy_of(sel) ? 0 : 1;
      end
    end
    mm_done = 1'b0;
  endtask

  task automatic release_done(input bit sel, output logic r, output logic b);
    @(negedge clk);
    in_valid = 1'b0;
    mm_done  = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    r = rdy_of(sel);
    b = busy_of(sel);
  endtask

  task automatic test_reset();
    reset = 1'b1; reset0 = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; mm_done = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
    n_cmp++; if (mm_start1 !== 1'b0) begin n_bad++; $display("FAIL reset_mm_start: got %b want 0", mm_start1); end
    n_cmp++; if (mm_data1 !== 8'h00) begin n_bad++; $display("FAIL reset_mm_data: got %0d want 0", mm_data1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got rdy=%b busy=%b want rdy=1 busy=0", in_ready1, busy1);
    end
  endtask

  task automatic test_basic();
    int cyc, wc, st, bl; bit found; logic [7:0] seq [12]; logic [7:0] e; logic r, b;
    drive_job(job_a, 1'b0, 1'b0, cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL basic_load_cycles: got %0d want 8", cyc); end
    watch(1'b0, -1, found, wc, seq, st, bl);
    n_cmp++; if (!found || wc !== 0) begin n_bad++; $display("FAIL basic_start_latency: found=%0d wait=%0d want found=1 wait=0", found, wc); end
    n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL basic_start_width: extra pulses %0d want 0", st); end
    n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL basic_busy: low for %0d cycles want 0", bl); end
    for (int j = 0; j < 12; j++) begin
      e = 8'h00;
      if (j >= 1 && j < 9) e = job_a[j-1];
      n_cmp++; if (seq[j] !== e) begin n_bad++; $display("FAIL basic_seq[%0d]: got %0d want %0d", j, seq[j], e); end
    end
    release_done(1'b0, r, b);
    n_cmp++; if (r !== 1'b1 || b !== 1'b0) begin n_bad++; $display("FAIL basic_done: got rdy=%b busy=%b want 1/0", r, b); end
  endtask

  task automatic test_bubbles();
    int cyc, wc, st, bl; bit found; logic [7:0] seq [12]; logic [7:0] e; logic r, b;
    drive_job(job_a, 1'b1, 1'b0, cyc);
    n_cmp++; if (cyc !== 15) begin n_bad++; $display("FAIL bubble_load_cycles: got %0d want 15", cyc); end
    watch(1'b0, -1, found, wc, seq, st, bl);
    n_cmp++; if (!found || wc !== 0) begin n_bad++; $display("FAIL bubble_start_latency: found=%0d wait=%0d want 1/0", found, wc); end
    for (int j = 0; j < 12; j++) begin
      e = 8'h00;
      if (j >= 1 && j < 9) e = job_a[j-1];
      n_cmp++; if (seq[j] !== e) begin n_bad++; $display("FAIL bubble_seq[%0d]: got %0d want %0d", j, seq[j], e); end
    end
    release_done(1'b0, r, b);
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL bubble_done: got rdy=%b want 1", r); end
  endtask

  task automatic test_wait_hold();
    int cyc, wc, st, bl, viol; bit found; logic [7:0] seq [12]; logic [7:0] e; logic r, b;
    drive_job(job_a, 1'b0, 1'b0, cyc);
    watch(1'b0, -1, found, wc, seq, st, bl);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hEE; mm_done = 1'b0;
      if (in_ready1 !== 1'b0 || busy1 !== 1'b1) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL hold_wait_done: %0d cycles with rdy=1 or busy=0, want 0", viol); end
    release_done(1'b0, r, b);
    n_cmp++; if (r !== 1'b1 || b !== 1'b0) begin n_bad++; $display("FAIL hold_release: got rdy=%b busy=%b want 1/0", r, b); end
    drive_job(job_b, 1'b0, 1'b0, cyc);
    watch(1'b0, -1, found, wc, seq, st, bl);
    n_cmp++; if (!found) begin n_bad++; $display("FAIL hold_jobb_start: found=%0d want 1", found); end
    for (int j = 0; j < 12; j++) begin
      e = 8'h00;
      if (j >= 1 && j < 9) e = job_b[j-1];
      n_cmp++; if (seq[j] !== e) begin n_bad++; $display("FAIL hold_seq[%0d]: got %0d want %0d", j, seq[j], e); end
    end
    release_done(1'b0, r, b);
  endtask

  task automatic test_done_ignored();
    int cyc, wc, st, bl; bit found; logic [7:0] seq [12]; logic [7:0] e; logic r, b;
    @(negedge clk);
    in_valid = 1'b0; mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    n_cmp++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL done_in_load_idle: got rdy=%b busy=%b want 1/0", in_ready1, busy1);
    end
    mm_done = 1'b1;
    drive_job(job_b, 1'b1, 1'b0, cyc);
    watch(1'b0, 4, found, wc, seq, st, bl);
    n_cmp++; if (!found || bl !== 0) begin n_bad++; $display("FAIL done_in_stream_busy: found=%0d busy_low=%0d want 1/0", found, bl); end
    for (int j = 0; j < 12; j++) begin
      e = 8'h00;
      if (j >= 1 && j < 9) e = job_b[j-1];
      n_cmp++; if (seq[j] !== e) begin n_bad++; $display("FAIL done_ign_seq[%0d]: got %0d want %0d", j, seq[j], e); end
    end
    n_cmp++; if (in_ready1 !== 1'b0) begin n_bad++; $display("FAIL done_ign_still_waiting: got rdy=%b want 0", in_ready1); end
    release_done(1'b0, r, b);
  endtask

  task automatic test_async_reset();
    int cyc, wc, st, bl, guard; bit found; logic [7:0] seq [12]; logic [7:0] e; logic r, b;
    drive_job(job_a, 1'b0, 1'b0, cyc);
    guard = 0;
    do begin
      @(negedge clk); in_valid = 1'b0; guard++;
    end while (mm_start1 !== 1'b1 && guard < 40);
    n_cmp++; if (mm_start1 !== 1'b1) begin n_bad++; $display("FAIL areset_start_timeout: got start=%b want 1", mm_start1); end
    repeat (4) @(negedge clk);
    n_cmp++; if (mm_data1 !== 8'd3) begin n_bad++; $display("FAIL areset_third_elem: got %0d want 3", mm_data1); end
    #20 reset = 1'b1;
    #1;
    n_cmp++; if (mm_data1 !== 8'h00 || busy1 !== 1'b0 || mm_start1 !== 1'b0) begin
      n_bad++; $display("FAIL areset_outputs: got data=%0d busy=%b start=%b want 0/0/0", mm_data1, busy1, mm_start1);
    end
    n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b want 1", in_ready1); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready1 !== 1'b1) begin n_bad++; $display("FAIL areset_release_rdy: got %b want 1", in_ready1); end
    drive_job(job_b, 1'b0, 1'b0, cyc);
    watch(1'b0, -1, found, wc, seq, st, bl);
    n_cmp++; if (!found || wc !== 0) begin n_bad++; $display("FAIL areset_restart: found=%0d wait=%0d want 1/0", found, wc); end
    for (int j = 0; j < 12; j++) begin
      e = 8'h00;
      if (j >= 1 && j < 9) e = job_b[j-1];
      n_cmp++; if (seq[j] !== e) begin n_bad++; $display("FAIL areset_seq[%0d]: got %0d want %0d", j, seq[j], e); end
    end
    release_done(1'b0, r, b);
  endtask

  task automatic test_gap0();
    int cyc, wc, st, bl; bit found; logic [7:0] seq [12]; logic [7:0] e; logic r, b;
    @(negedge clk);
    reset = 1'b1; reset0 = 1'b0; in_valid = 1'b0;
    drive_job(job_a, 1'b0, 1'b1, cyc);
    n_cmp++; if (cyc !== 8) begin n_bad++; $display("FAIL gap0_load_cycles: got %0d want 8", cyc); end
    watch(1'b1, -1, found, wc, seq, st, bl);
    n_cmp++; if (!found || wc !== 0 || st !== 0) begin
      n_bad++; $display("FAIL gap0_start: found=%0d wait=%0d extra=%0d want 1/0/0", found, wc, st);
    end
    for (int j = 0; j < 12; j++) begin
      e = 8'h00;
      if (j < 8) e = job_a[j];
      n_cmp++; if (seq[j] !== e) begin n_bad++; $display("FAIL gap0_seq[%0d]: got %0d want %0d", j, seq[j], e); end
    end
    release_done(1'b1, r, b);
    n_cmp++; if (r !== 1'b1 || b !== 1'b0) begin n_bad++; $display("FAIL gap0_done: got rdy=%b busy=%b want 1/0", r, b); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_wait_hold();
    test_done_ignored();
    test_async_reset();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
Name: matrix_feeder

Overview:
- Upstream stage of matrix_mult.
- Accepts operand elements from a valid/ready source and buffers one complete job: matrix A (M×N) followed by matrix B (M×N), both row-major.
- Once the job is buffered, replays it into matrix_mult: a one-cycle start pulse, a fixed gap, then one element per clock.
- Waits for matrix_mult's done before accepting the next job.

Parameters:
- DW, 8, element width in bits; must equal matrix_mult DW.
- M, 8, matrix row count; must equal matrix_mult m.
- N, 8, matrix column count; must equal matrix_mult n.
- GAP, 1, idle cycles between the mm_start pulse and the first streamed element; GAP >= 0.
- Local TOTAL = 2*M*N, buffer depth.
- Local CW = $clog2(TOTAL+1), counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  source has an element on in_data.
- in_data  input  DW  operand element, row-major, A then B.
- in_ready  output  1  feeder accepts in_data this cycle.
- mm_start  output  1  one-cycle start pulse to matrix_mult.
- mm_data  output  DW  element to matrix_mult data_in.
- mm_done  input  1  done from matrix_mult, level-sensitive.
- busy  output  1  high in every state except LOAD.

Behaviour:
- All outputs are registered except in_ready, which is decoded combinationally from state.
- Reset (asynchronous, any state, including mid-stream):
  - state=LOAD, wr_cnt=0, rd_cnt=0, gap_cnt=0.
  - mm_start=0, mm_data=0, busy=0.
  - Buffer RAM is not cleared; its contents are don't-care.
- States: LOAD, START, GAP, STREAM, WAIT_DONE.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid & in_ready; on each handshake, buf[wr_cnt] <= in_data and wr_cnt++.
  - On the handshake with wr_cnt==TOTAL-1, go to START. in_ready drops the next cycle.
  - in_valid low: hold with no change. Bubbles are allowed anywhere within a job.
- START:
  - mm_start=1 for exactly this cycle; wr_cnt<=0.
  - Next state is GAP if GAP>0, else STREAM.
- GAP:
  - Lasts exactly GAP cycles, counted by gap_cnt; mm_data=0; then go to STREAM.
- STREAM:
  - mm_data <= buf[rd_cnt] and rd_cnt++.
  - Element k is visible on mm_data during cycle (start cycle)+1+GAP+k, for k = 0..TOTAL-1.
  - After the element with rd_cnt==TOTAL-1: rd_cnt<=0, go to WAIT_DONE, and mm_data returns to 0 the following cycle.
- WAIT_DONE:
  - mm_data=0. When mm_done==1, go to LOAD; in_ready=1 the next cycle.
- mm_done is ignored in every state other than WAIT_DONE.
- in_valid is ignored outside LOAD; there is no back-pressure violation because in_ready=0 there.
- Latency:
  - Last accepted element to mm_start: 1 cycle.
  - mm_start to first element: 1+GAP cycles.
  - Full replay: TOTAL cycles.
- Counters never wrap past TOTAL-1. Hardware does not check the TOTAL >= 2 requirement; it is a documentation constraint only.
- Widths: pure storage, no arithmetic on data. Counter compares are done at CW bits.

Decomposition:
- Shared package matrix_pkg holds:
  - state encoding constants (LOAD=0, START=1, GAP=2, STREAM=3, WAIT_DONE=4, 3-bit);
  - default DW/M/N values;
  - a TOTAL helper function, also used by matrix_mult.
- One sub-module, feeder_ram: single-port DW×TOTAL register array with synchronous write and combinational read, with the read address muxed between wr_cnt and rd_cnt by state.
- The FSM and counters stay in matrix_feeder.

Test Plan (M=N=2, DW=8, GAP=1, clock period 200 ns):
1. Reset, then stream 1,2,3,4,4,3,2,1 with in_valid held high.
   - in_ready is high for 8 cycles.
   - mm_start pulses one cycle after the 8th handshake.
   - One zero cycle follows, then mm_data reads 1,2,3,4,4,3,2,1 on consecutive cycles, then 0.
   - busy stays high until mm_done.
2. Same data with in_valid deasserted every other cycle.
   - Identical mm_start/mm_data sequence; only the start time shifts.
3. In WAIT_DONE, hold mm_done=0 for 20 cycles and drive in_valid=1.
   - in_ready stays 0 and nothing is stored.
   - Raise mm_done: in_ready=1 next cycle.
   - Next job 5,6,7,8,9,10,11,12 replays correctly.
4. Pulse mm_done during LOAD and during STREAM.
   - No state change; replay is not truncated.
5. Assert reset after the 3rd streamed element.
   - Outputs go to 0 immediately (asynchronously).
   - After release: state=LOAD, in_ready=1.
   - A fresh 8-element job streams correctly from element 0.
6. Set GAP=0 and repeat scenario 1.
   - Element 1 appears on mm_data in the cycle immediately after mm_start.
